inst_fetch_unit: RTL and testbench

- Memory-side counterpart of the instruction register.
- Owns the program counter and issues word reads on the memory bus.
- Waits for the memory handshake, then drives the fetched word and a one-cycle load enable into the instruction register.
- Driven by the control FSM via a level fetch request; supports PC redirect (jump/branch) with flush of an in-flight fetch.

---
 rtl/inst_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads and hands fetched words to the IR.
// Optional macro FETCH_TIMEOUT_EN adds a bounded wait in REQ with a sticky fetch_err flag.
module inst_fetch_unit #(
    parameter int unsigned ADDR_WIDTH        = 8,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned RESET_PC          = 0,
    parameter int unsigned MEM_TIMEOUT       = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req,
    input  logic                         pc_load,
    input  logic [ADDR_WIDTH-1:0]        pc_load_val,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_rd,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_data,
    input  logic                         mem_ready,
    output logic [INSTRUCTION_WIDTH-1:0] ir_data,
    output logic                         ir_en,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         fetch_done,
    output logic                         busy,
    output logic                         fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
    logic                         pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]        pend_tgt_q, pend_tgt_d;
    logic [INSTRUCTION_WIDTH-1:0] ir_data_q, ir_data_d;
    logic                         ir_en_q, ir_en_d;
    logic                         fetch_done_q, fetch_done_d;
    logic                         mem_rd_q, mem_rd_d;
    logic                         busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fetch_err_q, fetch_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        ir_data_d    = ir_data_q;
        ir_en_d      = 1'b0;
        fetch_done_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_d       = wait_q;
        fetch_err_d  = fetch_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A fresh strobe beats a redirect left over from the LOAD cycle.
                if (pc_load) begin
                    pc_d   = pc_load_val;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_tgt_q;
                    pend_d = 1'b0;
                end else if (fetch_req) begin
                    state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    wait_d      = '0;
                    fetch_err_d = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                if (pc_load) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = pc_load_val;
                end
                if (mem_ready) begin
                    state_d = ST_LOAD;
                    // Word is dropped when any redirect (including this cycle's) is pending.
                    if (!pend_d) begin
                        ir_en_d      = 1'b1;
                        fetch_done_d = 1'b1;
                        ir_data_d    = mem_data[INSTRUCTION_WIDTH-1:0];
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d     = ST_IDLE;
                    fetch_err_d = 1'b1;
                    if (pend_d) begin
                        pc_d   = pend_tgt_d;
                        pend_d = 1'b0;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                if (pend_q) begin
                    pc_d = pend_tgt_q;
                end else begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                end
                // A strobe arriving now is carried into the next IDLE cycle.
                pend_d     = pc_load;
                pend_tgt_d = pc_load ? pc_load_val : pend_tgt_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_rd_d = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_RST;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            ir_data_q    <= '0;
            ir_en_q      <= 1'b0;
            fetch_done_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            ir_data_q    <= ir_data_d;
            ir_en_q      <= ir_en_d;
            fetch_done_q <= fetch_done_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q      <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign mem_rd     = mem_rd_q;
    assign ir_data    = ir_data_q;
    assign ir_en      = ir_en_q;
    assign fetch_done = fetch_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a per-cycle vector table plus hand-written corner sequences.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] ir_data;
    logic        ir_en;
    logic [7:0]  pc;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(
        .ADDR_WIDTH(8), .DATA_BUS_WIDTH(16), .INSTRUCTION_WIDTH(16),
        .RESET_PC(0), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_ready(mem_ready), .ir_data(ir_data),
        .ir_en(ir_en), .pc(pc), .fetch_done(fetch_done), .busy(busy),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        ld;
        logic [7:0]  ld_val;
        logic        rdy;
        logic [15:0] data;
        logic        e_rd;
        logic        e_en;
        logic        e_busy;
        logic [7:0]  e_pc;
        logic [15:0] e_ir;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic r, logic q, logic l, logic [7:0] v, logic y,
                                logic [15:0] d, logic rd, logic en, logic bz,
                                logic [7:0] p, logic [15:0] ir);
        vec_t t;
        t.rst_n = r; t.req = q; t.ld = l; t.ld_val = v; t.rdy = y; t.data = d;
        t.e_rd = rd; t.e_en = en; t.e_busy = bz; t.e_pc = p; t.e_ir = ir;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(input logic r, input logic q, input logic l, input logic [7:0] v,
                        input logic y, input logic [15:0] d);
        rst_n = r; fetch_req = q; pc_load = l; pc_load_val = v; mem_ready = y; mem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic rd, input logic en, input logic bz,
                              input logic [7:0] p, input logic [15:0] ir, input logic err);
        $display("txn %s: mem_rd=%b ir_en=%b busy=%b pc=%h ir_data=%h fetch_err=%b",
                 tag, mem_rd, ir_en, busy, pc, ir_data, fetch_err);
        chk({tag, ".mem_rd"},     16'(mem_rd),     16'(rd));
        chk({tag, ".ir_en"},      16'(ir_en),      16'(en));
        chk({tag, ".fetch_done"}, 16'(fetch_done), 16'(en));
        chk({tag, ".busy"},       16'(busy),       16'(bz));
        chk({tag, ".pc"},         16'(pc),         16'(p));
        chk({tag, ".mem_addr"},   16'(mem_addr),   16'(p));
        chk({tag, ".ir_data"},    ir_data,         ir);
        chk({tag, ".fetch_err"},  16'(fetch_err),  16'(err));
    endtask

    initial begin
        // rst req ld val rdy data | rd en busy pc ir
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        vecs[1]  = mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        vecs[2]  = mk(1, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 8'h00, 16'h0000);
        vecs[3]  = mk(1, 1, 0, 8'h00, 1, 16'hA5C3, 0, 1, 1, 8'h00, 16'hA5C3);
        vecs[4]  = mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h01, 16'hA5C3);
        vecs[5]  = mk(1, 0, 0, 8'h00, 1, 16'hFFFF, 0, 0, 0, 8'h01, 16'hA5C3);
        vecs[6]  = mk(1, 1, 1, 8'h40, 0, 16'h0000, 0, 0, 0, 8'h40, 16'hA5C3);
        vecs[7]  = mk(1, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 8'h40, 16'hA5C3);
        vecs[8]  = mk(1, 0, 0, 8'h00, 1, 16'h1234, 0, 1, 1, 8'h40, 16'h1234);
        vecs[9]  = mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h41, 16'h1234);
        vecs[10] = mk(1, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 8'h41, 16'h1234);
        vecs[11] = mk(1, 1, 0, 8'h00, 1, 16'h0F0F, 0, 1, 1, 8'h41, 16'h0F0F);
        vecs[12] = mk(1, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h42, 16'h0F0F);
        vecs[13] = mk(1, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 8'h42, 16'h0F0F);
        vecs[14] = mk(1, 0, 0, 8'h00, 1, 16'h7777, 0, 1, 1, 8'h42, 16'h7777);
        vecs[15] = mk(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 8'h43, 16'h7777);

        rst_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        mem_ready = 1'b0; mem_data = '0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].ld, vecs[i].ld_val, vecs[i].rdy, vecs[i].data);
            expect_out($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_en, vecs[i].e_busy,
                       vecs[i].e_pc, vecs[i].e_ir, 1'b0);
        end

        // Wait states: four cycles without ready, mem_rd held for five cycles total.
        begin
            int rd_cnt;
            int en_cnt;
            rd_cnt = 0;
            en_cnt = 0;
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            if (mem_rd) rd_cnt++;
            for (int w = 0; w < 4; w++) begin
                step(1, 0, 0, 8'h00, 0, 16'h0000);
                if (mem_rd) rd_cnt++;
                if (ir_en) en_cnt++;
            end
            step(1, 0, 0, 8'h00, 1, 16'hBEEF);
            expect_out("wait.load", 0, 1, 1, 8'h43, 16'hBEEF, 0);
            if (ir_en) en_cnt++;
            step(1, 0, 0, 8'h00, 0, 16'h0000);
            if (ir_en) en_cnt++;
            expect_out("wait.idle", 0, 0, 0, 8'h44, 16'hBEEF, 0);
            chk("wait.rd_cycles", 16'(rd_cnt), 16'd5);
            chk("wait.en_pulses", 16'(en_cnt), 16'd1);
        end

        // Flush: redirect during REQ discards the returned word.
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        expect_out("flush.req", 1, 0, 1, 8'h44, 16'hBEEF, 0);
        step(1, 0, 1, 8'h80, 0, 16'h0000);
        expect_out("flush.ld", 1, 0, 1, 8'h44, 16'hBEEF, 0);
        step(1, 0, 0, 8'h00, 1, 16'hDEAD);
        expect_out("flush.load", 0, 0, 1, 8'h44, 16'hBEEF, 0);
        step(1, 0, 0, 8'h00, 0, 16'h0000);
        expect_out("flush.idle", 0, 0, 0, 8'h80, 16'hBEEF, 0);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        expect_out("flush.refetch", 1, 0, 1, 8'h80, 16'hBEEF, 0);
        step(1, 0, 0, 8'h00, 1, 16'h5555);
        expect_out("flush.reload", 0, 1, 1, 8'h80, 16'h5555, 0);
        step(1, 0, 0, 8'h00, 0, 16'h0000);
        expect_out("flush.next", 0, 0, 0, 8'h81, 16'h5555, 0);

        // Redirect strobed during LOAD lands in the following IDLE cycle and blocks fetch_req.
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 0, 8'h00, 1, 16'h6666);
        expect_out("ldload.load", 0, 1, 1, 8'h81, 16'h6666, 0);
        step(1, 0, 1, 8'h10, 0, 16'h0000);
        expect_out("ldload.idle", 0, 0, 0, 8'h82, 16'h6666, 0);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        expect_out("ldload.apply", 0, 0, 0, 8'h10, 16'h6666, 0);

        // PC wrap from FF to 00.
        step(1, 0, 1, 8'hFF, 0, 16'h0000);
        expect_out("wrap.ld", 0, 0, 0, 8'hFF, 16'h6666, 0);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 0, 8'h00, 1, 16'h1111);
        expect_out("wrap.load", 0, 1, 1, 8'hFF, 16'h1111, 0);
        step(1, 0, 0, 8'h00, 0, 16'h0000);
        expect_out("wrap.idle", 0, 0, 0, 8'h00, 16'h1111, 0);

        // Reset in the middle of a fetch.
        step(1, 0, 1, 8'h22, 0, 16'h0000);
        step(1, 1, 0, 8'h00, 0, 16'h0000);
        expect_out("rstmid.req", 1, 0, 1, 8'h22, 16'h1111, 0);
        step(0, 1, 0, 8'h00, 0, 16'h0000);
        expect_out("rstmid.rst", 0, 0, 0, 8'h00, 16'h0000, 0);
        step(1, 0, 0, 8'h00, 1, 16'h9999);
        expect_out("rstmid.after", 0, 0, 0, 8'h00, 16'h0000, 0);

`ifdef FETCH_TIMEOUT_EN
        // Ready never arrives: REQ gives up after 15 cycles with a sticky error.
        begin
            int rd_cnt;
            rd_cnt = 0;
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            if (mem_rd) rd_cnt++;
            for (int w = 0; w < 14; w++) begin
                step(1, 0, 0, 8'h00, 0, 16'h0000);
                if (mem_rd) rd_cnt++;
            end
            chk("tmo.rd_cycles", 16'(rd_cnt), 16'd15);
            step(1, 0, 0, 8'h00, 0, 16'h0000);
            expect_out("tmo.exit", 0, 0, 0, 8'h00, 16'h0000, 1);
            step(1, 0, 0, 8'h00, 0, 16'h0000);
            expect_out("tmo.sticky", 0, 0, 0, 8'h00, 16'h0000, 1);
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            expect_out("tmo.clear", 1, 0, 1, 8'h00, 16'h0000, 0);
            step(1, 0, 0, 8'h00, 1, 16'h2468);
            expect_out("tmo.load", 0, 1, 1, 8'h00, 16'h2468, 0);
            step(1, 0, 0, 8'h00, 0, 16'h0000);
            expect_out("tmo.idle", 0, 0, 0, 8'h01, 16'h2468, 0);
        end
`else
        // Without the timeout the read is held indefinitely.
        begin
            int rd_cnt;
            rd_cnt = 0;
            step(1, 1, 0, 8'h00, 0, 16'h0000);
            for (int w = 0; w < 20; w++) begin
                step(1, 0, 0, 8'h00, 0, 16'h0000);
                if (mem_rd) rd_cnt++;
            end
            chk("longwait.rd_cycles", 16'(rd_cnt), 16'd20);
            expect_out("longwait.req", 1, 0, 1, 8'h00, 16'h0000, 0);
            step(1, 0, 0, 8'h00, 1, 16'h2468);
            expect_out("longwait.load", 0, 1, 1, 8'h00, 16'h2468, 0);
            step(1, 0, 0, 8'h00, 0, 16'h0000);
            expect_out("longwait.idle", 0, 0, 0, 8'h01, 16'h2468, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
